inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Fetch/sequencing end of the main-control interface for the single-cycle MIPS datapath.
- Holds the PC and fetches each instruction from instruction memory over a req/ack handshake.
- Presents the instruction (opCode = inst[31:26]) to the main control decoder.
- Takes the decoder's J and B outputs plus the ALU zero flag back, and computes the next PC from them.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] are forced to 0 internally.
- TIMEOUT_CYC, 255, number of un-acked request cycles after which fetch_err is set; range 1..65535.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  32  byte address of the request; bits [1:0] are always 0.
- imem_ack  input  1  memory has accepted the request and imem_rdata is valid this cycle.
- imem_rdata  input  32  instruction word; sampled only when imem_req & imem_ack.
- hold  input  1  stall request from the datapath; freezes the current instruction.
- J  input  1  jump control from the main decoder.
- B  input  1  branch control from the main decoder.
- zero  input  1  ALU zero flag.
- inst  output  32  current instruction.
- opCode  output  6  inst[31:26].
- inst_valid  output  1  inst is valid and being executed this cycle.
- pc  output  32  address of inst.
- pc_plus4  output  32  pc + 4, wrapping modulo 2^32.
- inst_count  output  32  number of retired instructions; wraps.
- fetch_err  output  1  sticky memory-timeout flag.

Behaviour:
- Reset values:
  - pc = RESET_PC & ~3; inst = 0; inst_valid = 0; imem_req = 0.
  - inst_count = 0; fetch_err = 0; wait counter = 0; state = START.
  - Reset takes priority over every other event.
- States START, FETCH, EXEC:
  - START: imem_req = 0; go to FETCH on the next cycle.
  - FETCH: imem_req = 1 and imem_addr = pc, both held stable until ack.
    - On imem_ack: latch inst <= imem_rdata, set inst_valid <= 1, clear the wait counter, go to EXEC.
    - A zero-wait ack (ack in the first FETCH cycle) is legal: first inst_valid is then 2 cycles after rst deasserts.
  - EXEC: imem_req = 0; inst_valid = 1.
    - If hold = 1: stay in EXEC; pc, inst and inst_count are unchanged; J/B/zero are ignored.
    - If hold = 0: pc <= next_pc; inst_count += 1; inst_valid <= 0; go to FETCH.
    - Each instruction therefore occupies at least 2 cycles: one in FETCH, one in EXEC.
- next_pc is combinational, evaluated in EXEC with hold = 0, using J/B/zero sampled that cycle:
  - J = 1: {pc_plus4[31:28], inst[25:0], 2'b00}. J has priority over B, so B may be X when J = 1.
  - else B & zero: pc_plus4 + {sign-extended inst[15:0], 2'b00}, 32-bit wrap.
  - else: pc_plus4. This also covers B = 1 with zero = 0.
- The PC wraps from 32'hFFFF_FFFC to 0.
- imem_ack while imem_req = 0 (START or EXEC, including a late ack after a mid-fetch reset) is ignored.
- Timeout:
  - The wait counter increments each FETCH cycle without ack.
  - When it reaches TIMEOUT_CYC, fetch_err <= 1; it stays 1 until rst.
  - The request stays asserted and fetch completes normally if ack later arrives.
- Reset mid-EXEC: the instruction is discarded and not counted; pc returns to RESET_PC.

Decomposition:
- Shared package mips_pkg:
  - state enum {START, FETCH, EXEC};
  - opcode constants OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100, OP_J 6'b000010;
  - NOP word 32'h0.
- One combinational sub-module, next_pc_calc: inputs pc_plus4, inst, J, B, zero; output next_pc. It is reusable for a later multicycle controller.

Test Plan:
- Reset, then zero-wait ack with rdata 32'h8C01_0004 (lw) -> imem_addr 0; inst_valid at cycle 2; opCode 6'b100011; after EXEC with J=0, B=0, pc = 4; inst_count = 1.
- At pc=0x10, beq 32'h1000_0003 with B=1, zero=1 -> next pc 0x20. Repeat with zero=0 -> pc 0x14.
- At pc=0x0000_0040, j 32'h0800_0100 with J=1, B=X -> pc 0x0000_0400.
- beq with offset 16'hFFFF at pc 0x8 -> pc 0x8.
- pc 32'hFFFF_FFFC, no branch -> pc 0.
- ack withheld TIMEOUT_CYC cycles -> fetch_err rises exactly at that count with imem_req still 1. Ack 3 cycles later -> instruction latched and fetch_err stays 1.
- hold=1 for 5 EXEC cycles with J=1 -> pc, inst and inst_count unchanged, inst_valid held. Release hold -> jump taken once.
- rst asserted during FETCH, then ack the next cycle -> ack ignored; imem_req 0 in START; refetch from RESET_PC; inst_count 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch/control slice.
package mips_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetchState_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection from the decoder's J/B outputs and the ALU zero flag.
// Purely combinational so a multicycle controller can reuse it unchanged.
module next_pc_calc (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] inst,
    input  logic        J,
    input  logic        B,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic [31:0] branchOffset;

    assign branchOffset = {{14{inst[15]}}, inst[15:0], 2'b00};

    // J wins outright, so B is don't-care whenever J is set.
    always_comb begin
        next_pc = pc_plus4;
        if (J)
            next_pc = {pc_plus4[31:28], inst[25:0], 2'b00};
        else if (B && zero)
            next_pc = pc_plus4 + branchOffset;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// PC holder and instruction fetcher: req/ack fetch from instruction memory,
// presents the instruction to the decoder and retires it into the next PC.
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        hold,
    input  logic        J,
    input  logic        B,
    input  logic        zero,
    output logic [31:0] inst,
    output logic [5:0]  opCode,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] inst_count,
    output logic        fetch_err
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [15:0] TIMEOUT_LIMIT    = 16'(TIMEOUT_CYC);

    fetchState_t state, nextState;
    logic [31:0] pcReg, instReg, countReg, nextPc;
    logic [15:0] waitCnt;
    logic        errReg;
    logic        fetchDone, retire;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst)
            state <= START;
        else
            state <= nextState;
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        nextState  = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        fetchDone  = 1'b0;
        retire     = 1'b0;
        unique case (state)
            START: nextState = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    fetchDone = 1'b1;
                    nextState = EXEC;
                end
            end
            EXEC: begin
                inst_valid = 1'b1;
                if (!hold) begin
                    retire    = 1'b1;
                    nextState = FETCH;
                end
            end
            default: nextState = START;
        endcase
    end

    next_pc_calc uNextPc (
        .pc_plus4 (pc_plus4),
        .inst     (instReg),
        .J        (J),
        .B        (B),
        .zero     (zero),
        .next_pc  (nextPc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pcReg    <= RESET_PC_ALIGNED;
            instReg  <= NOP_WORD;
            countReg <= 32'd0;
            waitCnt  <= 16'd0;
            errReg   <= 1'b0;
        end else begin
            if (fetchDone) begin
                instReg <= imem_rdata;
                waitCnt <= 16'd0;
            end else if (imem_req) begin
                // Saturate so a very long stall cannot wrap the counter.
                if (waitCnt != TIMEOUT_LIMIT)
                    waitCnt <= waitCnt + 16'd1;
                if (waitCnt == TIMEOUT_LIMIT - 16'd1)
                    errReg <= 1'b1;
            end
            if (retire) begin
                pcReg    <= nextPc;
                countReg <= countReg + 32'd1;
            end
        end
    end

    assign imem_addr  = pcReg;
    assign pc         = pcReg;
    assign pc_plus4   = pcReg + 32'd4;
    assign inst       = instReg;
    assign opCode     = instReg[31:26];
    assign inst_count = countReg;
    assign fetch_err  = errReg;

endmodule
